// File: rtl/rr_req_pend_if.sv
// Handshake bundle between the request sources / arbiter and rr_req_pend.
interface rr_req_pend_if #(
    parameter int W     = 32,
    parameter int CNT_W = 4,
    parameter int TOT_W = CNT_W + $clog2(W)
);
    logic [W-1:0]     push;
    logic [W-1:0]     push_rdy;
    logic [W-1:0]     req;
    logic [W-1:0]     gnt;
    logic             ack;
    logic             pend_any;
    logic [TOT_W-1:0] pend_tot;
    logic [W-1:0]     ovf;
    logic             err_gnt;
    logic             err_clr;

    // Sources, arbiter and status consumer side.
    modport master (
        output push, gnt, ack, err_clr,
        input  push_rdy, req, pend_any, pend_tot, ovf, err_gnt
    );

    // Accumulator side.
    modport slave (
        input  push, gnt, ack, err_clr,
        output push_rdy, req, pend_any, pend_tot, ovf, err_gnt
    );
endinterface

// File: rtl/rr_req_pend.sv
// Per-requester pending-request accumulator feeding a round-robin arbiter.
// Counts push pulses per port, presents a level req vector and retires one
// request per acknowledged one-hot grant. Overflow and illegal grants are
// reported through sticky flags cleared by err_clr.
module rr_req_pend #(
    parameter int W     = 32,
    parameter int CNT_W = 4,
    parameter int TOT_W = CNT_W + $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    rr_req_pend_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [W-1:0]     VEC_ONE = W'(1);

    logic [CNT_W-1:0] cnt [W];
    logic [TOT_W-1:0] pend_tot_q;
    logic [W-1:0]     ovf_q;
    logic             err_gnt_q;

    logic [W-1:0]     rdy;
    logic [W-1:0]     nz;
    logic [W-1:0]     inc;
    logic [W-1:0]     pop;
    logic [W-1:0]     drop;
    logic             gnt_multi;
    logic             gnt_idle;
    logic             gnt_bad;
    logic [TOT_W-1:0] n_inc;
    logic [TOT_W-1:0] n_pop;

    // Decode per-port status from the registered counters only.
    always_comb begin
        rdy = '0;
        nz  = '0;
        for (int unsigned i = 0; i < W; i++) begin
            rdy[i] = (cnt[i] != MAX);
            nz[i]  = (cnt[i] != '0);
        end
    end

    // Grant legality check and per-port increment/decrement enables.
    // An illegal acknowledged grant blocks every decrement in that cycle.
    always_comb begin
        gnt_multi = |(bus.gnt & (bus.gnt - VEC_ONE));
        gnt_idle  = |(bus.gnt & ~nz);
        gnt_bad   = bus.ack & (gnt_multi | gnt_idle);
        inc       = bus.push & rdy;
        drop      = bus.push & ~rdy;
        pop       = (bus.ack && !gnt_bad) ? (bus.gnt & nz) : '0;
    end

    // Population counts of this cycle's increments and decrements.
    always_comb begin
        n_inc = '0;
        n_pop = '0;
        for (int unsigned i = 0; i < W; i++) begin
            n_inc = n_inc + TOT_W'(inc[i]);
            n_pop = n_pop + TOT_W'(pop[i]);
        end
    end

    // Per-port saturating-free counters: a push at MAX is already filtered
    // by rdy, and a pop is only enabled on a non-zero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < W; i++) begin
                if (inc[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (pop[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // Aggregate count tracks the counters' next state so it equals their sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_tot_q <= '0;
        end else begin
            pend_tot_q <= pend_tot_q + n_inc - n_pop;
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= '0;
            err_gnt_q <= 1'b0;
        end else if (bus.err_clr) begin
            ovf_q     <= '0;
            err_gnt_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_q | drop;
            err_gnt_q <= err_gnt_q | gnt_bad;
        end
    end

    assign bus.push_rdy = rdy;
    assign bus.req      = nz;
    assign bus.pend_any = |nz;
    assign bus.pend_tot = pend_tot_q;
    assign bus.ovf      = ovf_q;
    assign bus.err_gnt  = err_gnt_q;
endmodule

// File: tb/tb_rr_req_pend.sv
// Directed and arbiter-driven checks of rr_req_pend with W=4, CNT_W=2.
module tb_rr_req_pend;
    localparam int W     = 4;
    localparam int CNT_W = 2;
    localparam int TOT_W = CNT_W + $clog2(W);

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    rr_req_pend_if #(.W(W), .CNT_W(CNT_W), .TOT_W(TOT_W)) bus ();

    rr_req_pend #(.W(W), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] arb(input logic [3:0] r, input int unsigned p);
        int unsigned idx;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (r[idx]) return 4'(1) << idx;
        end
        return 4'b0000;
    endfunction

    int unsigned m [4];
    int unsigned ptr;
    int unsigned msum;
    logic [3:0]  mreq;
    logic [3:0]  mrdy;
    logic [3:0]  g;
    logic [3:0]  p;
    int unsigned guard;

    initial begin
        bus.push    = 4'b1111;
        bus.gnt     = '0;
        bus.ack     = 1'b0;
        bus.err_clr = 1'b0;

        // Reset with push held
        tick();
        tick();
        check("rst_req", 32'(bus.req), 32'h0);
        check("rst_rdy", 32'(bus.push_rdy), 32'hF);
        check("rst_tot", 32'(bus.pend_tot), 32'h0);
        check("rst_any", 32'(bus.pend_any), 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'h0);
        check("rst_err", 32'(bus.err_gnt), 32'h0);
        rst = 1'b0;
        #1;
        check("rel_req", 32'(bus.req), 32'h0);
        tick();
        check("first_req", 32'(bus.req), 32'hF);
        check("first_tot", 32'(bus.pend_tot), 32'd4);
        check("first_any", 32'(bus.pend_any), 32'h1);
        bus.push = '0;

        // Reset mid-burst discards counts
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(bus.req), 32'h0);
        check("midrst_tot", 32'(bus.pend_tot), 32'h0);
        #2;
        rst = 1'b0;

        // Fill port 2, then overflow it
        bus.push = 4'b0100;
        tick();
        check("fill1_tot", 32'(bus.pend_tot), 32'd1);
        tick();
        check("fill2_tot", 32'(bus.pend_tot), 32'd2);
        tick();
        check("fill3_tot", 32'(bus.pend_tot), 32'd3);
        check("fill3_rdy", 32'(bus.push_rdy), 32'hB);
        check("fill3_ovf", 32'(bus.ovf), 32'h0);
        tick();
        check("ovf_tot", 32'(bus.pend_tot), 32'd3);
        check("ovf_flag", 32'(bus.ovf), 32'h4);
        check("ovf_req", 32'(bus.req), 32'h4);
        bus.push = '0;

        // Simultaneous push and pop on port 1 leaves count unchanged
        bus.push = 4'b0010;
        tick();
        check("p1_tot", 32'(bus.pend_tot), 32'd4);
        bus.ack = 1'b1;
        bus.gnt = 4'b0010;
        tick();
        check("pp_req", 32'(bus.req), 32'h6);
        check("pp_tot", 32'(bus.pend_tot), 32'd4);
        bus.push = '0;
        bus.ack  = 1'b0;
        bus.gnt  = '0;

        // Clear sticky overflow
        bus.err_clr = 1'b1;
        tick();
        check("clr_ovf", 32'(bus.ovf), 32'h0);
        bus.err_clr = 1'b0;

        // Port 0 full, push dropped while popped
        bus.push = 4'b0001;
        tick();
        tick();
        tick();
        check("p0full_tot", 32'(bus.pend_tot), 32'd7);
        bus.ack = 1'b1;
        bus.gnt = 4'b0001;
        tick();
        check("fullpop_tot", 32'(bus.pend_tot), 32'd6);
        check("fullpop_ovf", 32'(bus.ovf), 32'h1);
        check("fullpop_rdy", 32'(bus.push_rdy), 32'hB);
        bus.push = '0;
        // counts now: cnt0=2 cnt1=1 cnt2=3 cnt3=0

        // Multi-bit grant
        bus.gnt = 4'b0110;
        tick();
        check("multi_err", 32'(bus.err_gnt), 32'h1);
        check("multi_tot", 32'(bus.pend_tot), 32'd6);
        check("multi_req", 32'(bus.req), 32'h7);
        bus.ack     = 1'b0;
        bus.gnt     = '0;
        bus.err_clr = 1'b1;
        tick();
        check("clr_err", 32'(bus.err_gnt), 32'h0);
        check("clr_ovf2", 32'(bus.ovf), 32'h0);
        bus.err_clr = 1'b0;

        // Grant to an empty port
        bus.ack = 1'b1;
        bus.gnt = 4'b1000;
        tick();
        check("idle_err", 32'(bus.err_gnt), 32'h1);
        check("idle_tot", 32'(bus.pend_tot), 32'd6);
        // Clear has priority over a same-cycle violation
        bus.err_clr = 1'b1;
        tick();
        check("clrpri_err", 32'(bus.err_gnt), 32'h0);
        bus.err_clr = 1'b0;
        // ack with no grant is legal
        bus.gnt = 4'b0000;
        tick();
        check("ackz_err", 32'(bus.err_gnt), 32'h0);
        check("ackz_tot", 32'(bus.pend_tot), 32'd6);
        // illegal grant without ack is ignored
        bus.ack = 1'b0;
        bus.gnt = 4'b0110;
        tick();
        check("noack_err", 32'(bus.err_gnt), 32'h0);
        check("noack_tot", 32'(bus.pend_tot), 32'd6);
        // legal pop on port 2
        bus.ack = 1'b1;
        bus.gnt = 4'b0100;
        tick();
        check("pop2_tot", 32'(bus.pend_tot), 32'd5);
        check("pop2_rdy", 32'(bus.push_rdy), 32'hF);
        check("pop2_err", 32'(bus.err_gnt), 32'h0);
        bus.ack = 1'b0;
        bus.gnt = '0;

        // Arbiter-driven random traffic from a clean state
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int unsigned i = 0; i < 4; i++) m[i] = 0;
        ptr = 0;
        bus.ack = 1'b1;
        for (int unsigned c = 0; c < 3000; c++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mreq[i] = (m[i] != 0);
                mrdy[i] = (m[i] != 3);
            end
            g = arb(mreq, ptr);
            p = 4'($urandom) & mrdy;
            bus.gnt  = g;
            bus.push = p;
            for (int unsigned i = 0; i < 4; i++) begin
                if (p[i] && !g[i]) m[i] = m[i] + 1;
                else if (g[i] && !p[i]) m[i] = m[i] - 1;
                if (g[i]) ptr = (i + 1) % 4;
            end
            tick();
            msum = m[0] + m[1] + m[2] + m[3];
            for (int unsigned i = 0; i < 4; i++) mreq[i] = (m[i] != 0);
            check("rnd_tot", 32'(bus.pend_tot), msum);
            check("rnd_req", 32'(bus.req), 32'(mreq));
            check("rnd_ovf", 32'(bus.ovf), 32'h0);
            check("rnd_err", 32'(bus.err_gnt), 32'h0);
        end

        // Drain: every accepted push must be retired
        bus.push = '0;
        guard = 0;
        while (bus.pend_any && guard < 100) begin
            bus.gnt = arb(bus.req, ptr);
            for (int unsigned i = 0; i < 4; i++) if (bus.gnt[i]) ptr = (i + 1) % 4;
            tick();
            guard++;
        end
        check("drain_any", 32'(bus.pend_any), 32'h0);
        check("drain_tot", 32'(bus.pend_tot), 32'h0);
        check("drain_err", 32'(bus.err_gnt), 32'h0);
        bus.ack = 1'b0;
        bus.gnt = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
